unary_symbol_serializer: RTL
============================

// Module: unary_symbol_serializer
// PURPOSE
//  Parametrised successor to the fixed 2-bit symbol-to-binary mapper in the arithmetic-coding path.
//  Accepts one SYM_W-bit symbol per valid/ready handshake and emits its unary codeword serially, one bit per transfer.
//  Unary codeword: value v -> v ones followed by a single 0.
//  Downstream backpressure via bit_ready. Sits between the symbol source and the binary arithmetic coder.
// PARAMETERS
//  SYM_W    4   symbol width in bits (>=1); max symbol value 2^SYM_W-1
//  CNT_W    16  width of completed-codeword counter sym_cnt
//  ESC_THR  8   escape threshold, 1..2^SYM_W-1; used only when UNARY_ESCAPE_EN is defined
// PORTS
//  sys_clk    in   1      clock, rising edge
//  sys_reset  in   1      reset, asynchronous, active-low
//  sym_in     in   SYM_W  symbol value
//  sym_valid  in   1      sym_in valid
//  sym_ready  out  1      block can accept a symbol (high only in IDLE)
//  bit_out    out  1      current codeword bit
//  bit_valid  out  1      bit_out valid
//  bit_ready  in   1      downstream accepts bit_out this cycle
//  bit_last   out  1      bit_out is the final bit of the current codeword
//  busy       out  1      codeword in progress (state != IDLE)
//  sym_cnt    out  CNT_W  count of fully transferred codewords; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset:
//   - sys_reset=0 forces IDLE, sym_ready=1, bit_valid=0, bit_out=0, bit_last=0, busy=0, sym_cnt=0.
//   - Reset asserted mid-codeword aborts it. Remaining bits are dropped and sym_cnt is not incremented.
//  FSM states: IDLE, ONES, ZERO, RAW (RAW exists only with the macro defined).
//  Accept:
//   - Symbol is taken when sym_ready & sym_valid at a clock edge.
//   - sym_valid is ignored outside IDLE. No buffering; upstream must hold.
//  Transitions on accept of v:
//   - v==0 -> ZERO.
//   - v>0  -> ONES, with run counter = v.
//  Latency: first bit valid in the cycle after accept.
//  Output decode (registered state only, no combinational path from inputs):
//   - bit_valid = (state != IDLE).
//   - bit_out: 1 in ONES; 0 in ZERO; MSB of raw shift register in RAW.
//  Transfer = bit_valid & bit_ready. With bit_ready=0, state and bit_out hold unchanged; no bit is lost or repeated.
//  ONES:
//   - Each transfer decrements the run counter.
//   - On the transfer with counter==1, go to ZERO (or RAW for an escape).
//  ZERO:
//   - bit_last=1.
//   - On transfer: sym_cnt++, go to IDLE.
//  Back-to-back: sym_ready rises the cycle after the last transfer. Codeword of v costs v+1 bit cycles plus 1 idle/accept cycle.
//  Widths:
//   - Run counter is SYM_W bits. Maximum v=2^SYM_W-1 gives 2^SYM_W bits total.
//   - sym_cnt wraps all-ones -> 0 without a flag.
// CONFIGURATION
//  UNARY_ESCAPE_EN defined:
//   - v < ESC_THR: normal unary codeword.
//   - v >= ESC_THR: ESC_THR ones, then SYM_W raw bits of v, MSB first. No terminating 0.
//   - RAW state shifts on each transfer. bit_last is asserted on the final raw bit, which also increments sym_cnt.
//   - Codeword length = ESC_THR + SYM_W.
//  UNARY_ESCAPE_EN undefined:
//   - RAW state and raw shift register are not built. ESC_THR is ignored.
//   - Every symbol uses plain unary.
// TESTING
//  1. Reset:
//     - Hold sys_reset=0 -> sym_ready=1, bit_valid=0, busy=0, sym_cnt=0.
//     - Release; idle outputs stay stable.
//  2. Basic codewords (SYM_W=4, bit_ready=1): symbols 0,1,2,3
//     - Stream is 0 | 10 | 110 | 1110.
//     - bit_last on each terminating 0; sym_cnt=4.
//  3. Maximum symbol: 15, no macro
//     - 15 ones then 0 (16 bits); bit_last only on bit 16; sym_ready=0 throughout.
//  4. Backpressure: symbol 2, bit_ready=0 for 3 cycles after first bit valid
//     - bit_out holds 1, bit_valid holds 1.
//     - Final stream is still 110; sym_cnt +1 exactly once.
//  5. Reset mid-codeword: symbol 7, assert sys_reset after 3 bits
//     - Immediate IDLE, bit_valid=0, sym_cnt=0.
//     - Next symbol 1 emits 10 cleanly.
//  6. Escape (UNARY_ESCAPE_EN, ESC_THR=8): symbols 11 then 7
//     - Stream is 11111111 1011 (12 bits, no 0), then 11111110.
//     - sym_cnt=2.

Source files
------------

// File: rtl/unary_symbol_serializer.sv
// unary_symbol_serializer
//   Takes one SYM_W-bit symbol per valid/ready handshake and streams its unary
//   codeword (v ones, then a single 0) one bit per bit_valid/bit_ready transfer.
//   sym_cnt counts fully transferred codewords and wraps silently.
//   Optional feature macro: UNARY_ESCAPE_EN. When defined, symbols >= ESC_THR
//   are sent as ESC_THR ones followed by the SYM_W raw bits of the symbol,
//   MSB first, with no terminating 0.
module unary_symbol_serializer #(
    parameter int SYM_W   = 4,
    parameter int CNT_W   = 16,
    parameter int ESC_THR = 8
) (
    input  logic             sys_clk,
    input  logic             sys_reset,
    input  logic [SYM_W-1:0] sym_in,
    input  logic             sym_valid,
    output logic             sym_ready,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             bit_last,
    output logic             busy,
    output logic [CNT_W-1:0] sym_cnt
);

`ifdef UNARY_ESCAPE_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ONES = 2'd1,
        S_ZERO = 2'd2,
        S_RAW  = 2'd3
    } state_e;

    // Length of the ones prefix for escaped symbols, and of the raw tail.
    localparam logic [SYM_W-1:0] esc_v   = SYM_W'(ESC_THR);
    localparam logic [SYM_W-1:0] raw_len = SYM_W'(SYM_W);

    logic [SYM_W-1:0] raw_q, raw_d;
    logic             esc_q, esc_d;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ONES = 2'd1,
        S_ZERO = 2'd2
    } state_e;

    // The escape threshold has no meaning in the plain unary build.
    localparam int unused_esc_thr = ESC_THR;
`endif

    state_e           state_q, state_d;
    logic [SYM_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
    logic             transfer;

    assign transfer = bit_valid & bit_ready;

    // State register: all flops share the asynchronous active-low reset.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; reset here is asynchronous, hence it is in the sensitivity list.
    always_ff @(posedge sys_clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state_q   <= S_IDLE;
            run_q     <= '0;
            sym_cnt_q <= '0;
`ifdef UNARY_ESCAPE_EN
            raw_q     <= '0;
            esc_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            sym_cnt_q <= sym_cnt_d;
`ifdef UNARY_ESCAPE_EN
            raw_q     <= raw_d;
            esc_q     <= esc_d;
`endif
        end
    end

    // Next-state logic: accept in IDLE, advance only on a bit transfer.
    always_comb begin
        // NOTE: every variable gets a hold default first, so no path through
        // the case statement can leave it unassigned and infer a latch.
        state_d   = state_q;
        run_d     = run_q;
        sym_cnt_d = sym_cnt_q;
`ifdef UNARY_ESCAPE_EN
        raw_d     = raw_q;
        esc_d     = esc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (sym_valid) begin
                    if (sym_in == '0) begin
                        state_d = S_ZERO;
                    end else begin
                        state_d = S_ONES;
                        run_d   = sym_in;
                    end
`ifdef UNARY_ESCAPE_EN
                    raw_d = sym_in;
                    esc_d = (sym_in >= esc_v);
                    if (sym_in >= esc_v) begin
                        // esc_v >= 1, so an escaped symbol is never zero.
                        run_d = esc_v;
                    end
`endif
                end
            end
            S_ONES: begin
                if (transfer) begin
                    if (run_q == SYM_W'(1)) begin
`ifdef UNARY_ESCAPE_EN
                        if (esc_q) begin
                            state_d = S_RAW;
                            run_d   = raw_len;
                        end else begin
                            state_d = S_ZERO;
                            run_d   = '0;
                        end
`else
                        state_d = S_ZERO;
                        run_d   = '0;
`endif
                    end else begin
                        run_d = run_q - SYM_W'(1);
                    end
                end
            end
            S_ZERO: begin
                if (transfer) begin
                    sym_cnt_d = sym_cnt_q + CNT_W'(1);
                    state_d   = S_IDLE;
                end
            end
`ifdef UNARY_ESCAPE_EN
            S_RAW: begin
                if (transfer) begin
                    raw_d = raw_q << 1;
                    if (run_q == SYM_W'(1)) begin
                        sym_cnt_d = sym_cnt_q + CNT_W'(1);
                        state_d   = S_IDLE;
                        run_d     = '0;
                    end else begin
                        run_d = run_q - SYM_W'(1);
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: purely from registered state, no input-to-output path.
    always_comb begin
        sym_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        bit_valid = (state_q != S_IDLE);
        bit_out   = 1'b0;
        bit_last  = 1'b0;
        case (state_q)
            S_ONES: bit_out = 1'b1;
            S_ZERO: bit_last = 1'b1;
`ifdef UNARY_ESCAPE_EN
            S_RAW: begin
                bit_out  = raw_q[SYM_W-1];
                bit_last = (run_q == SYM_W'(1));
            end
`endif
            default: ;
        endcase
    end

    assign sym_cnt = sym_cnt_q;

endmodule
